// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// The master side (control/datapath) drives the request; the unit drives status and HI/LO.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  MDControl;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, MDControl, A, B,
    input  Busy, Done, DivZero, HI, LO
  );

  modport slave (
    input  start, MDControl, A, B,
    output Busy, Done, DivZero, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit producing HI/LO (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional MULDIV_FAST_MUL_EN: single-edge combinational multiply; divides stay iterative.
module muldiv_unit (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, opB_q, opB_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        isDiv_q, isDiv_d, qSign_q, qSign_d, rSign_q, rSign_d;
  logic        zero_q, zero_d, done_q, done_d, divZero_q, divZero_d;

  logic        isMulOp, isDivOp, opSigned;
  logic [31:0] magA, magB, quot, rem;
  logic [32:0] addSum, trial;
  logic [63:0] mulStep, divStep, fastProd;

  assign isMulOp  = (bus.MDControl[2:1] == 2'b00);
  assign isDivOp  = (bus.MDControl[2:1] == 2'b01);
  assign opSigned = ~bus.MDControl[0];
  assign magA     = (opSigned && bus.A[31]) ? -bus.A : bus.A;
  assign magB     = (opSigned && bus.B[31]) ? -bus.B : bus.B;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  logic [63:0] extA, extB;
  assign extA     = {{32{opSigned & bus.A[31]}}, bus.A};
  assign extB     = {{32{opSigned & bus.B[31]}}, bus.B};
  assign fastProd = extA * extB;
`else
  localparam bit FastMul = 1'b0;
  assign fastProd = '0;
`endif

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  assign addSum  = {1'b0, acc_q[63:32]} + {1'b0, opB_q};
  assign mulStep = acc_q[0] ? {addSum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
  assign trial   = acc_q[63:31] - {1'b0, opB_q};
  assign divStep = trial[32] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
  assign quot    = acc_q[31:0];
  assign rem     = acc_q[63:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      opB_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      qSign_q   <= 1'b0;
      rSign_q   <= 1'b0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opB_q     <= opB_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      isDiv_q   <= isDiv_d;
      qSign_q   <= qSign_d;
      rSign_q   <= rSign_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opB_d     = opB_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    isDiv_d   = isDiv_q;
    qSign_d   = qSign_q;
    rSign_d   = rSign_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    divZero_d = divZero_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (isMulOp && FastMul) begin
            {hi_d, lo_d} = fastProd;
            done_d       = 1'b1;
            divZero_d    = 1'b0;
          end else if (isMulOp || isDivOp) begin
            isDiv_d   = isDivOp;
            acc_d     = {32'b0, isDivOp ? magA : magB};
            opB_d     = isDivOp ? magB : magA;
            qSign_d   = opSigned & (bus.A[31] ^ bus.B[31]);
            rSign_d   = opSigned & bus.A[31];
            zero_d    = (bus.B == 32'd0);
            cnt_d     = '0;
            divZero_d = 1'b0;
            state_d   = RUN;
          end else if (bus.MDControl == 3'b100) begin
            hi_d = bus.A;
          end else if (bus.MDControl == 3'b101) begin
            lo_d = bus.A;
          end
        end
      end
      RUN: begin
        acc_d = isDiv_q ? divStep : mulStep;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIN;
      end
      FIN: begin
        // Zero divisor leaves rem equal to |A|, so the sign fix-up restores A itself
        if (isDiv_q) begin
          lo_d      = zero_q ? '1 : (qSign_q ? -quot : quot);
          hi_d      = rSign_q ? -rem : rem;
          divZero_d = zero_q;
        end else begin
          {hi_d, lo_d} = qSign_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Busy    = (state_q != IDLE);
  assign bus.Done    = done_q;
  assign bus.DivZero = divZero_q;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;

endmodule
